spi_miso_tx: RTL
================

Name: spi_miso_tx

Overview:
Read-path transmit stage of the SPI slave. It sits directly downstream of the RAM, accepting each read-data word (dout with its tx_valid strobe) and serializing it onto miso while the frame select ss_n is low. A one-word holding register allows back-to-back words with no gap bit. Overrun and completion are flagged to the control logic.

Parameters:
DATA_W, 8, width of a RAM read word
MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first
IDLE_LEVEL, 0, miso level when no bit is being driven

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
ss_n  input  1  frame select, active-low; high = idle/abort
tx_valid  input  1  one-cycle strobe from RAM; tx_data is valid
tx_data  input  DATA_W  RAM read word
miso  output  1  serial output, registered
busy  output  1  shifter active or holding register full
tx_done  output  1  one-cycle pulse, last bit of a word on miso
overrun  output  1  sticky; a word was dropped

Behaviour:
- Reset (rst=0, async): miso=IDLE_LEVEL, busy=0, tx_done=0, overrun=0; state IDLE; bit counter=0; hold empty; shifter cleared.
- States:
  - IDLE: ss_n=1. Goes to ARMED on a clk edge with ss_n=0.
  - ARMED: ss_n=0, nothing to send.
  - SHIFT: a word is being driven.
- Accept (ss_n=0):
  - On an edge with tx_valid=1, if the shifter is free (ARMED, or SHIFT on its last-bit cycle with hold empty), tx_data loads into the shifter.
  - The first bit appears on miso on that same edge, so there is 1 cycle of latency from the strobe cycle.
  - State goes to SHIFT and the counter loads DATA_W-1.
- SHIFT:
  - Each edge drives the next bit (MSB_FIRST order) and decrements the counter.
  - A word occupies exactly DATA_W consecutive cycles on miso.
  - tx_done=1 during the cycle the last bit is on miso.
- End of word (edge after the last-bit cycle):
  - If hold is full, the hold word loads into the shifter with no gap bit, and hold empties.
  - Otherwise, if tx_valid=1 on that edge, tx_data loads directly with no gap.
  - Otherwise the state goes to ARMED and miso=IDLE_LEVEL.
- tx_valid while SHIFT (not at the direct-load point):
  - If hold is empty, tx_data is captured into hold.
  - If hold is full, the word is dropped, overrun<=1 and hold is unchanged.
  - When the direct-load point coincides with a full hold, the hold word loads and the new word goes to hold.
- tx_valid with ss_n=1: ignored; no load, no overrun.
- ss_n rising at any time, including mid-word:
  - On the next edge the state goes to IDLE; shifter, hold and counter are cleared.
  - miso=IDLE_LEVEL, busy=0, no tx_done for the aborted word.
  - overrun clears on this edge.
- busy = (state==SHIFT) or hold full. It is registered and updates on the same edge as the state.
- overrun is cleared only by reset or by ss_n returning high.
- Reset mid-word: all outputs return to reset values immediately. No partial word resumes after reset release.

Test Plan:
1. Reset, then ss_n=0, tx_valid pulse with tx_data=8'hA5 -> miso=1,0,1,0,0,1,0,1 on the next 8 cycles; tx_done high in the 8th only; busy high for 8 cycles, then miso=0.
2. Back-to-back: load 8'h3C, then pulse 8'hC3 at bit 3 -> 16 consecutive bits 00111100 11000011 with no gap; tx_done at cycles 8 and 16.
3. Overrun: load 8'hFF, then pulse 8'h11 and 8'h22 during shift -> overrun=1; output is FF then 11; 8'h22 is never sent.
4. Abort: load 8'h81, raise ss_n after 3 bits -> next edge miso=0, busy=0, no tx_done; overrun cleared; the next frame sends a fresh word correctly.
5. ss_n=1 with tx_valid pulse 8'h55 -> miso stays IDLE_LEVEL, busy=0, overrun=0.
6. MSB_FIRST=0 and 8'h01 -> miso=1,0,0,0,0,0,0,0. Assert rst mid-word -> outputs reset asynchronously.

Source files
------------

// File: rtl/spi_miso_tx.sv
// Read-path transmit stage: serializes RAM read words onto miso while ss_n is low,
// with a one-word holding register for gapless back-to-back transfer.
module spi_miso_tx #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              miso,
    output logic              busy,
    output logic              tx_done,
    output logic              overrun
);

    localparam int unsigned    CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_SHIFT
    } state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   shreg, shreg_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [DATA_W-1:0]   hold, hold_nxt;
    logic                hold_full, hold_full_nxt;
    logic                miso_nxt, busy_nxt, done_nxt, overrun_nxt;
    logic                load_en;
    logic [DATA_W-1:0]   load_word;

    // Bit that goes on the wire first for a freshly loaded word.
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    // Remaining bits after the current bit has been driven.
    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // State and datapath registers; everything resets to idle values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            miso      <= IDLE_LEVEL;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            cnt       <= cnt_nxt;
            hold      <= hold_nxt;
            hold_full <= hold_full_nxt;
            miso      <= miso_nxt;
            busy      <= busy_nxt;
            tx_done   <= done_nxt;
            overrun   <= overrun_nxt;
        end
    end

    // Next-state, shifter, holding register and flag logic.
    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        cnt_nxt       = cnt;
        hold_nxt      = hold;
        hold_full_nxt = hold_full;
        miso_nxt      = miso;
        done_nxt      = 1'b0;
        overrun_nxt   = overrun;
        load_en       = 1'b0;
        load_word     = '0;

        if (ss_n) begin
            // Frame closed or aborted: drop everything, including overrun.
            state_nxt     = S_IDLE;
            shreg_nxt     = '0;
            cnt_nxt       = '0;
            hold_nxt      = '0;
            hold_full_nxt = 1'b0;
            miso_nxt      = IDLE_LEVEL;
            overrun_nxt   = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_ARMED;
                    miso_nxt  = IDLE_LEVEL;
                end
                S_ARMED: begin
                    if (tx_valid) begin
                        load_en   = 1'b1;
                        load_word = tx_data;
                    end
                end
                S_SHIFT: begin
                    if (cnt == '0) begin
                        // Last bit on the wire: chain the next word with no gap.
                        if (hold_full) begin
                            load_en   = 1'b1;
                            load_word = hold;
                            if (tx_valid) begin
                                hold_nxt = tx_data;
                            end else begin
                                hold_nxt      = '0;
                                hold_full_nxt = 1'b0;
                            end
                        end else if (tx_valid) begin
                            load_en   = 1'b1;
                            load_word = tx_data;
                        end else begin
                            state_nxt = S_ARMED;
                            shreg_nxt = '0;
                            miso_nxt  = IDLE_LEVEL;
                        end
                    end else begin
                        miso_nxt  = first_bit(shreg);
                        shreg_nxt = advance(shreg);
                        cnt_nxt   = cnt - CNT_W'(1);
                        done_nxt  = (cnt == CNT_W'(1));
                        if (tx_valid) begin
                            if (!hold_full) begin
                                hold_nxt      = tx_data;
                                hold_full_nxt = 1'b1;
                            end else begin
                                overrun_nxt = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    miso_nxt  = IDLE_LEVEL;
                end
            endcase

            if (load_en) begin
                state_nxt = S_SHIFT;
                miso_nxt  = first_bit(load_word);
                shreg_nxt = advance(load_word);
                cnt_nxt   = CNT_LAST;
                done_nxt  = (DATA_W == 1);
            end
        end

        busy_nxt = (state_nxt == S_SHIFT) || hold_full_nxt;
    end

endmodule
